// File: rtl/config_port_arbiter_if.sv
// Bundle of configuration-source request signals and ConfigFSM-facing write stream
// for config_port_arbiter; slave = arbiter side, master = sources/sink side.
interface config_port_arbiter_if #(
  parameter int NumChannels = 3,
  parameter int DataWidth   = 32,
  parameter int OwnerWidth  = 2
);
  logic [NumChannels-1:0]           Active;
  logic [NumChannels*DataWidth-1:0] WriteData;
  logic [NumChannels-1:0]           WriteStrobe;
  logic                             ConfigBusy;
  logic [DataWidth-1:0]             ConfigWriteData;
  logic                             ConfigWriteStrobe;
  logic [OwnerWidth-1:0]            Owner;
  logic                             OwnerValid;
  logic                             FSM_Reset;
  logic [15:0]                      DropCount;
  logic                             Overflow;

  modport slave (
    input  Active, WriteData, WriteStrobe, ConfigBusy,
    output ConfigWriteData, ConfigWriteStrobe, Owner, OwnerValid,
           FSM_Reset, DropCount, Overflow
  );

  modport master (
    output Active, WriteData, WriteStrobe, ConfigBusy,
    input  ConfigWriteData, ConfigWriteStrobe, Owner, OwnerValid,
           FSM_Reset, DropCount, Overflow
  );
endinterface

// File: rtl/config_port_arbiter.sv
// N-channel fixed-priority, sticky-ownership configuration-port arbiter with word FIFO.
// Optional statistics (DropCount/Overflow) are built only when CONFIG_ARB_STATS_EN is defined.
module config_port_arbiter #(
  parameter int NumChannels   = 3,
  parameter int DataWidth     = 32,
  parameter int FifoDepth     = 4,
  parameter int ReleaseCycles = 4,
  parameter int OwnerWidth    = 2
) (
  input logic                 CLK,
  input logic                 resetn,
  config_port_arbiter_if.slave bus
);
  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = $clog2(ReleaseCycles + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [OwnerWidth-1:0]   owner_q, owner_d;
  logic                    owner_valid_q, owner_valid_d;
  logic                    fsm_reset_q, fsm_reset_d;
  logic [CntW-1:0]         rel_cnt_q, rel_cnt_d;

  logic                    owner_active_s;
  logic                    owner_stb_s;
  logic [DataWidth-1:0]    owner_data_s;

  logic [DataWidth-1:0]    mem_q [FifoDepth];
  logic [PtrW:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]           rd_ptr_q, rd_ptr_d;
  logic                    empty_s, full_s;
  logic                    accept_s, pop_fifo_s, bypass_s, push_req_s, push_s;

  logic [DataWidth-1:0]    cw_data_q, cw_data_d;
  logic                    cw_strobe_q, cw_strobe_d;

  function automatic logic [OwnerWidth-1:0] lowest_idx(input logic [NumChannels-1:0] req);
    logic [OwnerWidth-1:0] idx;
    idx = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      idx = req[i] ? OwnerWidth'(i) : idx;
    end
    return idx;
  endfunction

  // Select the current owner's Active, strobe and data lanes.
  always_comb begin
    owner_active_s = 1'b0;
    owner_stb_s    = 1'b0;
    owner_data_s   = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (owner_q == OwnerWidth'(i)) begin
        owner_active_s = bus.Active[i];
        owner_stb_s    = bus.WriteStrobe[i];
        owner_data_s   = bus.WriteData[i*DataWidth +: DataWidth];
      end else begin
        owner_active_s = owner_active_s;
      end
    end
  end

  // Ownership FSM next-state: grant, hold, release hold-off and re-arbitration.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    fsm_reset_d   = 1'b0;
    rel_cnt_d     = rel_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.Active) begin
          owner_d       = lowest_idx(bus.Active);
          owner_valid_d = 1'b1;
          fsm_reset_d   = 1'b1;
          rel_cnt_d     = '0;
          state_d       = ST_OWNED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWNED: begin
        if (!owner_active_s) begin
          rel_cnt_d = CntW'(1);
          state_d   = ST_RELEASE;
        end else begin
          rel_cnt_d = '0;
        end
      end
      ST_RELEASE: begin
        if (owner_active_s) begin
          rel_cnt_d = '0;
          state_d   = ST_OWNED;
        end else if (rel_cnt_q >= CntW'(ReleaseCycles)) begin
          // Owner is inactive here, so any set Active bit is a different channel.
          rel_cnt_d = '0;
          if (|bus.Active) begin
            owner_d       = lowest_idx(bus.Active);
            owner_valid_d = 1'b1;
            fsm_reset_d   = 1'b1;
            state_d       = ST_OWNED;
          end else begin
            owner_d       = '0;
            owner_valid_d = 1'b0;
            state_d       = ST_IDLE;
          end
        end else begin
          rel_cnt_d = rel_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d       = ST_IDLE;
        owner_d       = '0;
        owner_valid_d = 1'b0;
        rel_cnt_d     = '0;
      end
    endcase
  end

  // Ownership FSM state register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      fsm_reset_q   <= 1'b0;
      rel_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      fsm_reset_q   <= fsm_reset_d;
      rel_cnt_q     <= rel_cnt_d;
    end
  end

  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign full_s     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign accept_s   = owner_valid_q && owner_stb_s;
  assign pop_fifo_s = !empty_s && !bus.ConfigBusy;
  // An empty FIFO lets an accepted word go straight to the output register.
  assign bypass_s   = accept_s && empty_s && !bus.ConfigBusy;
  assign push_req_s = accept_s && !bypass_s;
  assign push_s     = push_req_s && (!full_s || pop_fifo_s);

  // FIFO pointer and output-stage next-state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cw_data_d   = cw_data_q;
    cw_strobe_d = 1'b0;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_fifo_s) begin
      rd_ptr_d    = rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
      cw_data_d   = mem_q[rd_ptr_q[PtrW-1:0]];
      cw_strobe_d = 1'b1;
    end else if (bypass_s) begin
      cw_data_d   = owner_data_s;
      cw_strobe_d = 1'b1;
    end else begin
      cw_strobe_d = 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= owner_data_s;
    end
  end

  // FIFO pointers and registered write stream.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cw_data_q   <= '0;
      cw_strobe_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cw_data_q   <= cw_data_d;
      cw_strobe_q <= cw_strobe_d;
    end
  end

  assign bus.ConfigWriteData   = cw_data_q;
  assign bus.ConfigWriteStrobe = cw_strobe_q;
  assign bus.Owner             = owner_q;
  assign bus.OwnerValid        = owner_valid_q;
  assign bus.FSM_Reset         = fsm_reset_q;

`ifdef CONFIG_ARB_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        overflow_q, overflow_d;
  logic        ovf_s;
  logic [4:0]  drops_s;
  logic [16:0] drop_sum_s;

  function automatic logic [4:0] popcount(input logic [NumChannels-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < NumChannels; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  assign ovf_s      = push_req_s && full_s && !pop_fifo_s;
  // Every strobe bit is a drop except the one word that actually got stored or issued.
  assign drops_s    = popcount(bus.WriteStrobe) - {4'd0, (accept_s && !ovf_s)};
  assign drop_sum_s = {1'b0, drop_cnt_q} + {12'd0, drops_s};

  // Saturating drop counter and sticky overflow next-state.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q || ovf_s;
    if (drop_sum_s[16]) begin
      drop_cnt_d = 16'hFFFF;
    end else begin
      drop_cnt_d = drop_sum_s[15:0];
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      drop_cnt_q <= 16'd0;
      overflow_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.DropCount = drop_cnt_q;
  assign bus.Overflow  = overflow_q;
`else
  assign bus.DropCount = 16'd0;
  assign bus.Overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed bench for config_port_arbiter: scoreboard queue of expected words,
// popped by a write-stream monitor; control outputs checked inline.
module tb_config_port_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int OW = 2;
`ifdef CONFIG_ARB_STATS_EN
  localparam int StatsEn = 1;
`else
  localparam int StatsEn = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passes = 0;
  logic [DW-1:0] exp_q[$];

  config_port_arbiter_if #(.NumChannels(N), .DataWidth(DW), .OwnerWidth(OW)) bus();

  config_port_arbiter #(
    .NumChannels(N), .DataWidth(DW), .FifoDepth(4), .ReleaseCycles(4), .OwnerWidth(OW)
  ) dut (
    .CLK(clk),
    .resetn(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write-stream monitor: every issued word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.ConfigWriteStrobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {31'd0, bus.ConfigWriteStrobe}, 32'd0);
      end else begin
        check("wdata", bus.ConfigWriteData, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int ch, input logic [DW-1:0] val);
    bus.WriteStrobe[ch] = 1'b1;
    bus.WriteData[ch*DW +: DW] = val;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.Active = '0;
    bus.WriteStrobe = '0;
    bus.WriteData = '0;
    bus.ConfigBusy = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.Active = '0;
    bus.WriteStrobe = '0;
    bus.WriteData = '0;
    bus.ConfigBusy = 1'b0;
    tick();
    check("rst_owner", 32'(bus.Owner), 32'd0);
    check("rst_valid", 32'(bus.OwnerValid), 32'd0);
    check("rst_fsmreset", 32'(bus.FSM_Reset), 32'd0);
    check("rst_strobe", 32'(bus.ConfigWriteStrobe), 32'd0);
    check("rst_data", bus.ConfigWriteData, 32'd0);
    check("rst_drop", 32'(bus.DropCount), 32'd0);
    check("rst_ovf", 32'(bus.Overflow), 32'd0);

    // Single owner, three back-to-back words.
    do_reset();
    bus.Active = 3'b010;
    tick();
    check("t1_owner", 32'(bus.Owner), 32'd1);
    check("t1_valid", 32'(bus.OwnerValid), 32'd1);
    check("t1_pulse", 32'(bus.FSM_Reset), 32'd1);
    tick();
    check("t1_pulse_len", 32'(bus.FSM_Reset), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      set_word(1, 32'hA5A50000 + 32'(i));
      exp_q.push_back(32'hA5A50000 + 32'(i));
      tick();
      check("t1_strobe", 32'(bus.ConfigWriteStrobe), 32'd1);
      check("t1_no_pulse", 32'(bus.FSM_Reset), 32'd0);
    end
    bus.WriteStrobe = '0;
    tick();
    check("t1_strobe_end", 32'(bus.ConfigWriteStrobe), 32'd0);
    check("t1_hold_data", bus.ConfigWriteData, 32'hA5A50003);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Priority / stickiness, then release hand-over after ReleaseCycles+1.
    do_reset();
    bus.Active = 3'b100;
    tick();
    check("t2_owner2", 32'(bus.Owner), 32'd2);
    tick();
    bus.Active = 3'b101;
    tick();
    tick();
    check("t2_sticky", 32'(bus.Owner), 32'd2);
    check("t2_sticky_pulse", 32'(bus.FSM_Reset), 32'd0);
    bus.Active = 3'b001;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t2_holdoff_owner", 32'(bus.Owner), 32'd2);
      check("t2_holdoff_pulse", 32'(bus.FSM_Reset), 32'd0);
    end
    tick();
    check("t2_new_owner", 32'(bus.Owner), 32'd0);
    check("t2_new_valid", 32'(bus.OwnerValid), 32'd1);
    check("t2_switch_pulse", 32'(bus.FSM_Reset), 32'd1);
    tick();
    check("t2_switch_pulse_len", 32'(bus.FSM_Reset), 32'd0);

    // Release glitch shorter than the hold-off, then a full release to idle.
    do_reset();
    bus.Active = 3'b010;
    tick();
    tick();
    bus.Active = 3'b000;
    tick();
    tick();
    bus.Active = 3'b010;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t3_glitch_owner", 32'(bus.Owner), 32'd1);
      check("t3_glitch_valid", 32'(bus.OwnerValid), 32'd1);
      check("t3_glitch_pulse", 32'(bus.FSM_Reset), 32'd0);
    end
    bus.Active = 3'b000;
    for (int i = 0; i < 4; i++) tick();
    check("t3_idle_late", 32'(bus.OwnerValid), 32'd1);
    tick();
    check("t3_idle_valid", 32'(bus.OwnerValid), 32'd0);
    check("t3_idle_pulse", 32'(bus.FSM_Reset), 32'd0);

    // Grant-cycle and non-owner strobes are dropped.
    do_reset();
    bus.Active = 3'b001;
    set_word(0, 32'hDEAD0000);
    tick();
    bus.WriteStrobe = '0;
    check("t4_grant_drop", 32'(bus.DropCount), 32'(StatsEn));
    for (int i = 0; i < 3; i++) begin
      set_word(1, 32'hBAD00000 + 32'(i));
      tick();
    end
    bus.WriteStrobe = '0;
    tick();
    check("t4_nonowner_drop", 32'(bus.DropCount), 32'(4 * StatsEn));
    set_word(0, 32'h0000C0DE);
    set_word(1, 32'h0000BEEF);
    exp_q.push_back(32'h0000C0DE);
    tick();
    bus.WriteStrobe = '0;
    check("t4_mixed_strobe", 32'(bus.ConfigWriteStrobe), 32'd1);
    check("t4_mixed_drop", 32'(bus.DropCount), 32'(5 * StatsEn));
    tick();

    // Overflow with ConfigBusy, then drain with a simultaneous push on full.
    do_reset();
    bus.Active = 3'b001;
    tick();
    tick();
    bus.ConfigBusy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_word(0, 32'hC0DE0000 + 32'(i));
      if (i < 4) exp_q.push_back(32'hC0DE0000 + 32'(i));
      tick();
      check("t5_busy_no_strobe", 32'(bus.ConfigWriteStrobe), 32'd0);
    end
    check("t5_overflow", 32'(bus.Overflow), 32'(StatsEn));
    check("t5_drop", 32'(bus.DropCount), 32'(2 * StatsEn));
    bus.ConfigBusy = 1'b0;
    set_word(0, 32'hC0DE0006);
    exp_q.push_back(32'hC0DE0006);
    tick();
    bus.WriteStrobe = '0;
    check("t5_drain0", 32'(bus.ConfigWriteStrobe), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_drain", 32'(bus.ConfigWriteStrobe), 32'd1);
    end
    tick();
    check("t5_drain_end", 32'(bus.ConfigWriteStrobe), 32'd0);
    check("t5_full_pushpop_drop", 32'(bus.DropCount), 32'(2 * StatsEn));
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with words still buffered.
    do_reset();
    bus.Active = 3'b010;
    tick();
    tick();
    bus.ConfigBusy = 1'b1;
    set_word(1, 32'h11110001);
    tick();
    set_word(1, 32'h11110002);
    tick();
    bus.WriteStrobe = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_owner", 32'(bus.Owner), 32'd0);
    check("t6_valid", 32'(bus.OwnerValid), 32'd0);
    check("t6_strobe", 32'(bus.ConfigWriteStrobe), 32'd0);
    bus.Active = '0;
    bus.ConfigBusy = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t6_no_output", 32'(bus.ConfigWriteStrobe), 32'd0);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
